dm_store_buffer: RTL and testbench
==================================

# dm_store_buffer

- Write buffer between the MEM pipeline stage and the 8 KB data memory.
- Accepts byte, halfword and word stores from the pipeline and converts each one into a word address, a byte-enable and a lane-aligned write word.
- Queues the stores in a small FIFO and drains them into the memory's single write port, one per cycle, whenever the port is free.
- Stalls any load whose word address matches a queued store, so loads never read stale data.

## Interface
Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..8.

Ports:
- Clk  in  1  rising-edge clock
- Reset_n  in  1  synchronous, active-low reset
- St_Valid  in  1  store request this cycle
- St_Ready  out  1  buffer can accept a store; equals !full
- St_Addr  in  13  byte address [12:0]
- St_Type  in  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as misaligned)
- St_Data  in  32  store data, right-justified
- Misalign  out  1  combinational; St_Valid with an illegal alignment or type
- Ld_Valid  in  1  load in MEM stage
- Ld_Addr  in  11  load word address [12:2]
- Ld_Stall  out  1  combinational; a load hits a queued entry
- DM_Busy  in  1  memory port claimed by another user this cycle
- DM_A  out  11  memory word address [12:2]
- DM_BE  out  4  memory byte-enable
- DM_WD  out  32  memory write data
- DM_We  out  1  memory write strobe
- Empty  out  1  no valid entries
- Count  out  4  number of valid entries, 0..DEPTH

## Operation
- **Alignment.**
  - Word requires St_Addr[1:0]==0.
  - Halfword requires St_Addr[0]==0.
  - Byte is always legal.
  - Any violation, or St_Type==11, asserts Misalign while St_Valid is high. The store is discarded and the FIFO is unchanged.
- **Lane generation.**
  - Word: BE=1111, WD=data.
  - Halfword at St_Addr[1]=0: BE=0011, data[15:0] in WD[15:0].
  - Halfword at St_Addr[1]=1: BE=1100, data[15:0] in WD[31:16].
  - Byte: BE is a one-hot bit at St_Addr[1:0], data[7:0] placed in that lane.
  - Unused lanes are 0.
- **Enqueue.** Happens at a rising edge when St_Valid && St_Ready && !Misalign. The entry stores {word addr, BE, WD}.
- **Drain.**
  - DM_We = !Empty && !DM_Busy.
  - DM_A, DM_BE and DM_WD show the head entry.
  - The head is popped on the same edge that the memory writes.
  - While Empty, DM_A, DM_BE and DM_WD are 0.
- **Simultaneous enqueue and pop.**
  - Both happen; Count is unchanged.
  - St_Ready ignores a pop in the same cycle, so a full buffer rejects a store even while draining.
- **Load hazard.**
  - Ld_Stall = Ld_Valid && (any valid entry's word addr == Ld_Addr).
  - The head being drained this cycle still counts as a match.
  - A store being enqueued this cycle is not compared.
- **Order.** Drain order is strictly FIFO.
- **Reset.**
  - Any edge with Reset_n low clears the pointers and sets Count=0.
  - This also forces Empty=1, DM_We=0 and zero DM outputs, discarding every pending store, including one mid-drain.
  - Reset has priority over enqueue and pop.

## Timing
- An accepted store can be written to memory at the next rising edge at the earliest: a 1-cycle minimum store-to-memory latency.
- DM_Busy high holds the head in place with no timeout.
- Misalign, Ld_Stall, St_Ready and DM_We are combinational from inputs and state. Count and Empty come directly from registers.
- Pointer wrap-around is modulo DEPTH. Full means Count==DEPTH.

## Configuration
- **SB_MERGE_EN defined:** an accepted store merges into the tail entry instead of allocating a new one when all of the following hold:
  - the word addresses match;
  - the tail is not the head being popped this cycle;
  - the merged BE (old OR new) is one of 1111, 0011, 1100, 0001, 0010, 0100, 1000.

  In a merge, new lanes overwrite old lanes and Count is unchanged. Otherwise the store allocates a new entry. St_Ready remains !full, so a full buffer does not merge either.
- **SB_MERGE_EN undefined:** every accepted store allocates a new entry.

## Test plan
- **Reset.** Reset_n low for 2 cycles, then high → Empty=1, Count=0, DM_We=0, DM_A=0, DM_BE=0, DM_WD=0, St_Ready=1.
- **Lane placement.**
  - Byte store St_Addr=0x0013, data 0x000000AB → next cycle DM_A=0x004, DM_BE=1000, DM_WD=0xAB000000, DM_We=1.
  - Halfword store at 0x0006, data 0x1234 → DM_BE=1100, DM_WD=0x12340000.
- **Misalign and fill.**
  - Word store at 0x0002 → Misalign=1, Count stays 0.
  - With DM_Busy=1, 4 legal stores → Count=4 and St_Ready=0; a fifth store is dropped.
  - DM_Busy low → entries drain in order over 4 cycles.
- **Simultaneous enqueue and pop.** Count=2, DM_Busy=0, store accepted → Count stays 2; memory writes the head.
- **Load hazard.**
  - Queue a store to word 0x010 with DM_Busy=1; Ld_Valid with Ld_Addr=0x010 → Ld_Stall=1.
  - Ld_Addr=0x011 → Ld_Stall=0.
  - DM_Busy low, pop → next cycle Ld_Stall=0.
- **Merge (SB_MERGE_EN).**
  - Bytes to 0x0020 and 0x0021 with DM_Busy=1 → one entry, BE=0011.
  - Then a byte to 0x0023 → new entry, because 1011 is not a legal merge pattern.
  - Without the macro, the same sequence gives Count=3.

Source files
------------

// File: rtl/dm_store_buffer.sv
// Store buffer between the MEM stage and the 8 KB data memory: lane-aligns stores,
// queues them and drains one per free cycle. Optional tail merging via SB_MERGE_EN.
module dm_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        St_Valid,
  output logic        St_Ready,
  input  logic [12:0] St_Addr,
  input  logic [1:0]  St_Type,
  input  logic [31:0] St_Data,
  output logic        Misalign,
  input  logic        Ld_Valid,
  input  logic [10:0] Ld_Addr,
  output logic        Ld_Stall,
  input  logic        DM_Busy,
  output logic [10:0] DM_A,
  output logic [3:0]  DM_BE,
  output logic [31:0] DM_WD,
  output logic        DM_We,
  output logic        Empty,
  output logic [3:0]  Count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [10:0]   entAddr_q [DEPTH];
  logic [3:0]    entBe_q   [DEPTH];
  logic [31:0]   entWd_q   [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [3:0]    count_q, count_d;
  logic          empty_q;

  logic          misalignRaw;
  logic [3:0]    laneBe;
  logic [31:0]   laneWd;
  logic          push, pop, alloc, doMerge, ldHit;
  logic [PW-1:0] tailIdx, scanIdx;

  always_comb begin
    misalignRaw = 1'b0;
    laneBe      = 4'b0000;
    laneWd      = 32'h0;
    case (St_Type)
      2'b00: begin
        if (St_Addr[1:0] != 2'b00) misalignRaw = 1'b1;
        else begin
          laneBe = 4'b1111;
          laneWd = St_Data;
        end
      end
      2'b01: begin
        if (St_Addr[0]) misalignRaw = 1'b1;
        else if (St_Addr[1]) begin
          laneBe = 4'b1100;
          laneWd = {St_Data[15:0], 16'h0};
        end else begin
          laneBe = 4'b0011;
          laneWd = {16'h0, St_Data[15:0]};
        end
      end
      2'b10: begin
        laneBe = 4'b0001 << St_Addr[1:0];
        laneWd = {24'h0, St_Data[7:0]} << {St_Addr[1:0], 3'b000};
      end
      default: misalignRaw = 1'b1;
    endcase
  end

  assign Misalign = St_Valid && misalignRaw;
  assign St_Ready = (count_q != 4'(DEPTH));
  assign push     = St_Valid && St_Ready && !misalignRaw;
  assign pop      = !empty_q && !DM_Busy;
  assign alloc    = push && !doMerge;
  assign tailIdx  = tail_q - PW'(1);

`ifdef SB_MERGE_EN
  logic [3:0]  mergeBe;
  logic [31:0] mergeWd;
  logic        mergeLegal;

  // Merging is refused when the tail is the sole entry leaving this cycle
  always_comb begin
    mergeBe = entBe_q[tailIdx] | laneBe;
    mergeWd = entWd_q[tailIdx];
    for (int b = 0; b < 4; b++) begin
      if (laneBe[b]) mergeWd[8*b +: 8] = laneWd[8*b +: 8];
    end
    case (mergeBe)
      4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: mergeLegal = 1'b1;
      default:                            mergeLegal = 1'b0;
    endcase
    doMerge = push && (count_q != 4'd0) && (entAddr_q[tailIdx] == St_Addr[12:2])
              && !(pop && (count_q == 4'd1)) && mergeLegal;
  end
`else
  assign doMerge = 1'b0;
`endif

  always_comb begin
    ldHit   = 1'b0;
    scanIdx = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      scanIdx = head_q + PW'(k);
      if ((4'(k) < count_q) && (entAddr_q[scanIdx] == Ld_Addr)) ldHit = 1'b1;
    end
  end

  assign Ld_Stall = Ld_Valid && ldHit;

  assign DM_We = pop;
  assign DM_A  = empty_q ? 11'h0 : entAddr_q[head_q];
  assign DM_BE = empty_q ? 4'h0  : entBe_q[head_q];
  assign DM_WD = empty_q ? 32'h0 : entWd_q[head_q];
  assign Empty = empty_q;
  assign Count = count_q;

  assign head_d  = head_q + PW'(pop);
  assign tail_d  = tail_q + PW'(alloc);
  assign count_d = count_q + 4'(alloc) - 4'(pop);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 4'd0;
      empty_q <= 1'b1;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      empty_q <= (count_d == 4'd0);
    end
  end

  // Entry payloads need no reset; the pointers decide what is valid
  always_ff @(posedge Clk) begin
    if (Reset_n && alloc) begin
      entAddr_q[tail_q] <= St_Addr[12:2];
      entBe_q[tail_q]   <= laneBe;
      entWd_q[tail_q]   <= laneWd;
    end
`ifdef SB_MERGE_EN
    if (Reset_n && doMerge) begin
      entBe_q[tailIdx] <= mergeBe;
      entWd_q[tailIdx] <= mergeWd;
    end
`endif
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Randomized self-checking bench for dm_store_buffer against a queue-based reference model.
module tb_dm_store_buffer;

  localparam int DEPTH = 4;

  logic        Clk;
  logic        Reset_n;
  logic        St_Valid;
  logic        St_Ready;
  logic [12:0] St_Addr;
  logic [1:0]  St_Type;
  logic [31:0] St_Data;
  logic        Misalign;
  logic        Ld_Valid;
  logic [10:0] Ld_Addr;
  logic        Ld_Stall;
  logic        DM_Busy;
  logic [10:0] DM_A;
  logic [3:0]  DM_BE;
  logic [31:0] DM_WD;
  logic        DM_We;
  logic        Empty;
  logic [3:0]  Count;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    logic [10:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
  } entry_t;

  entry_t refQ[$];

  dm_store_buffer #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .St_Valid(St_Valid), .St_Ready(St_Ready), .St_Addr(St_Addr),
    .St_Type(St_Type), .St_Data(St_Data), .Misalign(Misalign),
    .Ld_Valid(Ld_Valid), .Ld_Addr(Ld_Addr), .Ld_Stall(Ld_Stall),
    .DM_Busy(DM_Busy), .DM_A(DM_A), .DM_BE(DM_BE), .DM_WD(DM_WD),
    .DM_We(DM_We), .Empty(Empty), .Count(Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Store decoding from the alignment and lane rules, written with plain arithmetic
  function automatic void refLane(input logic [12:0] addr, input logic [1:0] typ, input logic [31:0] data,
                                  output bit bad, output logic [3:0] be, output logic [31:0] wd);
    int off;
    off = int'(addr[1:0]);
    bad = 1'b0;
    be  = 4'h0;
    wd  = 32'h0;
    case (typ)
      2'd0: begin bad = (off != 0); be = 4'hF; wd = data; end
      2'd1: begin bad = (off % 2 != 0); be = 4'(3 << off); wd = (data & 32'hFFFF) << (8 * off); end
      2'd2: begin be = 4'(1 << off); wd = (data & 32'hFF) << (8 * off); end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      be = 4'h0;
      wd = 32'h0;
    end
  endfunction

  function automatic bit legalPattern(input logic [3:0] be);
    return be inside {4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
  endfunction

  // Drive one cycle, compare all outputs mid-cycle, then advance the model on the edge
  task automatic applyStimulus(input logic rstN, input logic sv, input logic [12:0] addr,
                               input logic [1:0] typ, input logic [31:0] data,
                               input logic lv, input logic [10:0] laddr, input logic busy);
    bit          bad, expStall, expPop, expPush, merged;
    logic [3:0]  be, mBe;
    logic [31:0] wd, mWd;
    entry_t      e;
    Reset_n  = rstN;
    St_Valid = sv;
    St_Addr  = addr;
    St_Type  = typ;
    St_Data  = data;
    Ld_Valid = lv;
    Ld_Addr  = laddr;
    DM_Busy  = busy;
    #2;
    refLane(addr, typ, data, bad, be, wd);
    expStall = 1'b0;
    foreach (refQ[i]) if (lv && refQ[i].a == laddr) expStall = 1'b1;
    expPop  = (refQ.size() > 0) && !busy;
    expPush = sv && !bad && (refQ.size() < DEPTH);
    checkOutput("Count",    32'(Count),    32'(refQ.size()));
    checkOutput("Empty",    32'(Empty),    32'(refQ.size() == 0));
    checkOutput("St_Ready", 32'(St_Ready), 32'(refQ.size() < DEPTH));
    checkOutput("Misalign", 32'(Misalign), 32'(sv && bad));
    checkOutput("Ld_Stall", 32'(Ld_Stall), 32'(expStall));
    checkOutput("DM_We",    32'(DM_We),    32'(expPop));
    checkOutput("DM_A",     32'(DM_A),     (refQ.size() > 0) ? 32'(refQ[0].a)  : 32'h0);
    checkOutput("DM_BE",    32'(DM_BE),    (refQ.size() > 0) ? 32'(refQ[0].be) : 32'h0);
    checkOutput("DM_WD",    DM_WD,         (refQ.size() > 0) ? refQ[0].wd      : 32'h0);
    @(posedge Clk);
    if (!rstN) begin
      refQ.delete();
    end else begin
      merged = 1'b0;
`ifdef SB_MERGE_EN
      if (expPush && refQ.size() > 0 && refQ[$].a == addr[12:2] && !(expPop && refQ.size() == 1)) begin
        mBe = refQ[$].be | be;
        mWd = refQ[$].wd;
        for (int b = 0; b < 4; b++) if (be[b]) mWd[8*b +: 8] = wd[8*b +: 8];
        if (legalPattern(mBe)) begin
          refQ[$].be = mBe;
          refQ[$].wd = mWd;
          merged = 1'b1;
        end
      end
`else
      mBe = 4'h0;
      mWd = 32'h0;
`endif
      if (expPush && !merged) begin
        e.a  = addr[12:2];
        e.be = be;
        e.wd = wd;
        refQ.push_back(e);
      end
      if (expPop) void'(refQ.pop_front());
    end
    #1;
  endtask

  task automatic idle(input logic busy);
    applyStimulus(1'b1, 1'b0, 13'h0, 2'd0, 32'h0, 1'b0, 11'h0, busy);
  endtask

  initial begin
    Reset_n = 1'b0; St_Valid = 1'b0; St_Addr = '0; St_Type = '0; St_Data = '0;
    Ld_Valid = 1'b0; Ld_Addr = '0; DM_Busy = 1'b0;
    repeat (2) @(posedge Clk);
    #1;

    applyStimulus(1'b0, 1'b0, 13'h0, 2'd0, 32'h0, 1'b0, 11'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 13'h0, 2'd0, 32'h0, 1'b0, 11'h0, 1'b0);
    idle(1'b0);

    // Byte lane placement; shown at the head one cycle later
    applyStimulus(1'b1, 1'b1, 13'h0013, 2'd2, 32'h000000AB, 1'b0, 11'h0, 1'b0);
    DM_Busy = 1'b0; St_Valid = 1'b0; #1;
    checkOutput("byte_DM_A",  32'(DM_A),  32'h004);
    checkOutput("byte_DM_BE", 32'(DM_BE), 32'h8);
    checkOutput("byte_DM_WD", DM_WD,      32'hAB000000);
    checkOutput("byte_DM_We", 32'(DM_We), 32'h1);
    idle(1'b0);
    applyStimulus(1'b1, 1'b1, 13'h0006, 2'd1, 32'h00001234, 1'b0, 11'h0, 1'b0);
    DM_Busy = 1'b0; St_Valid = 1'b0; #1;
    checkOutput("half_DM_BE", 32'(DM_BE), 32'hC);
    checkOutput("half_DM_WD", DM_WD,      32'h12340000);
    idle(1'b0);

    // Misaligned word, then fill to full under busy and drain
    applyStimulus(1'b1, 1'b1, 13'h0002, 2'd0, 32'hDEADBEEF, 1'b0, 11'h0, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 1'b1, 13'(16'h0100 + 4 * i), 2'd0, $urandom, 1'b0, 11'h0, 1'b1);
    checkOutput("full_Count", 32'(Count), 32'd4);
    for (int i = 0; i < 5; i++) idle(1'b0);

    // Simultaneous enqueue and pop at Count=2
    applyStimulus(1'b1, 1'b1, 13'h0200, 2'd0, 32'h11111111, 1'b0, 11'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 13'h0204, 2'd0, 32'h22222222, 1'b0, 11'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 13'h0208, 2'd0, 32'h33333333, 1'b0, 11'h0, 1'b0);
    checkOutput("simul_Count", 32'(Count), 32'd2);
    for (int i = 0; i < 3; i++) idle(1'b0);

    // Load hazard on word 0x010
    applyStimulus(1'b1, 1'b1, 13'h0040, 2'd0, 32'hCAFEF00D, 1'b0, 11'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 13'h0, 2'd0, 32'h0, 1'b1, 11'h010, 1'b1);
    applyStimulus(1'b1, 1'b0, 13'h0, 2'd0, 32'h0, 1'b1, 11'h011, 1'b1);
    applyStimulus(1'b1, 1'b0, 13'h0, 2'd0, 32'h0, 1'b1, 11'h010, 1'b0);
    applyStimulus(1'b1, 1'b0, 13'h0, 2'd0, 32'h0, 1'b1, 11'h010, 1'b0);

    // Merge sequence: bytes at 0x20, 0x21, then 0x23
    applyStimulus(1'b1, 1'b1, 13'h0020, 2'd2, 32'h000000A1, 1'b0, 11'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 13'h0021, 2'd2, 32'h000000B2, 1'b0, 11'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 13'h0023, 2'd2, 32'h000000C3, 1'b0, 11'h0, 1'b1);
`ifdef SB_MERGE_EN
    checkOutput("merge_Count", 32'(Count), 32'd2);
`else
    checkOutput("merge_Count", 32'(Count), 32'd3);
`endif
    for (int i = 0; i < 4; i++) idle(1'b0);

    // Random traffic over a narrow address window to provoke hazards and merges
    for (int i = 0; i < 400; i++) begin
      logic [1:0] typ;
      typ = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      applyStimulus(($urandom_range(0, 49) != 0),
                    ($urandom_range(0, 2) != 0),
                    13'(13'h0040 + 4 * $urandom_range(0, 5) + $urandom_range(0, 3)),
                    typ, $urandom,
                    1'($urandom_range(0, 1)),
                    11'(11'h010 + $urandom_range(0, 6)),
                    1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
